// File: rtl/phase_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : phase_bank_ctrl
// Purpose  : Double-buffered phase store and commit scheduler. Phase writes
//            are staged in the shadow bank. A host commit swaps the shadow and
//            active banks at the next PWM frame boundary. The PWM side reads
//            (active + calibration) mod 2^PHASE_W through a registered port.
// Ports    : clk, rst                  - clock, synchronous active-high reset
//            phase_wr_en/phase_wr_data - phase/commit command strobe and word
//            calib_wr_en/calib_wr_data - calibration offset strobe and word
//            frame_start               - PWM period boundary pulse
//            rd_addr / rd_phase        - PWM read address / calibrated phase
//            active_bank, commit_pending, swap_pulse, clearing,
//            cmd_error, frame_count    - status outputs
// Revision : 1.0 - initial release
// ============================================================================
module phase_bank_ctrl #(
  parameter int NUM_CHANNELS = 256,
  parameter int PHASE_W      = 8,
  parameter int ADDR_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               phase_wr_en,
  input  logic [31:0]        phase_wr_data,
  input  logic               calib_wr_en,
  input  logic [31:0]        calib_wr_data,
  input  logic               frame_start,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [PHASE_W-1:0] rd_phase,
  output logic               active_bank,
  output logic               commit_pending,
  output logic               swap_pulse,
  output logic               clearing,
  output logic               cmd_error,
  output logic [15:0]        frame_count
);

  localparam int              IDX_W    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);
  localparam logic [8:0]       NUM_CH9  = 9'(NUM_CHANNELS);

  typedef enum logic [0:0] {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  logic [PHASE_W-1:0] bank0 [NUM_CHANNELS];
  logic [PHASE_W-1:0] bank1 [NUM_CHANNELS];
  logic [PHASE_W-1:0] calib [NUM_CHANNELS];

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   clr_addr_q, clr_addr_d;
  logic [PHASE_W-1:0] rd_phase_q, rd_phase_d;
  logic               active_bank_q, active_bank_d;
  logic               commit_pending_q, commit_pending_d;
  logic               swap_pulse_q, swap_pulse_d;
  logic               cmd_error_q, cmd_error_d;
  logic [15:0]        frame_count_q, frame_count_d;

  // Command decode
  logic               run;
  logic [1:0]         ph_op;
  logic               ph_addr_ok, cal_addr_ok;
  logic               ph_accept, ph_we, commit, ph_err, cal_we, cal_err, swap;
  logic [IDX_W-1:0]   ph_idx, cal_idx, rd_idx;
  logic [PHASE_W-1:0] ph_val, cal_val, rd_act, rd_sum;
  logic               unused_bits;

  assign run         = (state_q == S_RUN);
  assign ph_op       = phase_wr_data[17:16];
  assign ph_addr_ok  = {1'b0, phase_wr_data[7:0]} < NUM_CH9;
  assign cal_addr_ok = {1'b0, calib_wr_data[7:0]} < NUM_CH9;
  assign ph_idx      = phase_wr_data[IDX_W-1:0];
  assign cal_idx     = calib_wr_data[IDX_W-1:0];
  assign rd_idx      = rd_addr[IDX_W-1:0];
  assign ph_val      = phase_wr_data[8 +: PHASE_W];
  assign cal_val     = calib_wr_data[8 +: PHASE_W];

  assign ph_accept = run & phase_wr_en & ph_addr_ok & ((ph_op == 2'b01) | (ph_op == 2'b10));
  assign ph_we     = ph_accept & (ph_op == 2'b01);
  assign commit    = ph_accept & (ph_op == 2'b10);
  assign ph_err    = phase_wr_en & ~ph_accept;
  assign cal_we    = run & calib_wr_en & cal_addr_ok;
  assign cal_err   = calib_wr_en & ~cal_we;
  assign swap      = run & frame_start & commit_pending_q;

  // Read uses the registered bank select, so a swap affects reads from the
  // following cycle onward.
  assign rd_act = active_bank_q ? bank1[rd_idx] : bank0[rd_idx];
  assign rd_sum = rd_act + calib[rd_idx];

  assign unused_bits = ^{phase_wr_data, calib_wr_data, rd_addr};

  always_comb begin
    state_d          = state_q;
    clr_addr_d       = clr_addr_q;
    rd_phase_d       = '0;
    active_bank_d    = active_bank_q;
    commit_pending_d = commit_pending_q;
    swap_pulse_d     = 1'b0;
    cmd_error_d      = ph_err | cal_err;
    frame_count_d    = frame_count_q;
    if (state_q == S_CLEAR) begin
      clr_addr_d = clr_addr_q + 1'b1;
      if (clr_addr_q == LAST_IDX) begin
        state_d = S_RUN;
      end
    end else begin
      rd_phase_d = rd_sum;
      // A swap always consumes the pending commit; a commit arriving with one
      // already pending adds nothing.
      if (swap) begin
        active_bank_d    = ~active_bank_q;
        commit_pending_d = 1'b0;
        frame_count_d    = frame_count_q + 16'd1;
        swap_pulse_d     = 1'b1;
      end else if (commit) begin
        commit_pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_CLEAR;
      clr_addr_q       <= '0;
      rd_phase_q       <= '0;
      active_bank_q    <= 1'b0;
      commit_pending_q <= 1'b0;
      swap_pulse_q     <= 1'b0;
      cmd_error_q      <= 1'b0;
      frame_count_q    <= '0;
    end else begin
      state_q          <= state_d;
      clr_addr_q       <= clr_addr_d;
      rd_phase_q       <= rd_phase_d;
      active_bank_q    <= active_bank_d;
      commit_pending_q <= commit_pending_d;
      swap_pulse_q     <= swap_pulse_d;
      cmd_error_q      <= cmd_error_d;
      frame_count_q    <= frame_count_d;
    end
  end

  // Storage. Phase writes go to the pre-swap shadow bank, so a write in the
  // swap cycle lands in the bank that becomes active.
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_CLEAR) begin
      bank0[clr_addr_q] <= '0;
      bank1[clr_addr_q] <= '0;
      calib[clr_addr_q] <= '0;
    end else if (!rst) begin
      if (ph_we && active_bank_q) begin
        bank0[ph_idx] <= ph_val;
      end
      if (ph_we && !active_bank_q) begin
        bank1[ph_idx] <= ph_val;
      end
      if (cal_we) begin
        calib[cal_idx] <= cal_val;
      end
    end
  end

  assign rd_phase       = rd_phase_q;
  assign active_bank    = active_bank_q;
  assign commit_pending = commit_pending_q;
  assign swap_pulse     = swap_pulse_q;
  assign clearing       = (state_q == S_CLEAR);
  assign cmd_error      = cmd_error_q;
  assign frame_count    = frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_phase_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_phase_bank_ctrl
// Purpose  : Self-checking bench for phase_bank_ctrl: directed scenarios plus
//            randomized traffic against an array-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phase_bank_ctrl;

  localparam int N = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        phase_wr_en = 1'b0;
  logic [31:0] phase_wr_data = '0;
  logic        calib_wr_en = 1'b0;
  logic [31:0] calib_wr_data = '0;
  logic        frame_start = 1'b0;
  logic [7:0]  rd_addr = '0;
  logic [7:0]  rd_phase;
  logic        active_bank, commit_pending, swap_pulse, clearing, cmd_error;
  logic [15:0] frame_count;

  phase_bank_ctrl #(.NUM_CHANNELS(N), .PHASE_W(8), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .phase_wr_en(phase_wr_en), .phase_wr_data(phase_wr_data),
    .calib_wr_en(calib_wr_en), .calib_wr_data(calib_wr_data),
    .frame_start(frame_start), .rd_addr(rd_addr), .rd_phase(rd_phase),
    .active_bank(active_bank), .commit_pending(commit_pending),
    .swap_pulse(swap_pulse), .clearing(clearing), .cmd_error(cmd_error),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  m_bank [2][N];
  logic [7:0]  m_calib [N];
  int          m_left;
  logic        m_act, m_pend, m_swap, m_err;
  logic [7:0]  m_rd;
  logic [15:0] m_fc;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pw(input logic [1:0] op, input logic [7:0] ph, input logic [7:0] a);
    logic [13:0] junk;
    junk = 14'($urandom);
    return {junk, op, ph, a};
  endfunction

  function automatic logic [31:0] cw(input logic [7:0] a, input logic [7:0] off);
    logic [15:0] junk;
    junk = 16'($urandom);
    return {junk, off, a};
  endfunction

  // One clock: drive inputs, advance the model at the edge, check after it.
  task automatic cyc(input logic pe, input logic [31:0] pd, input logic ce,
                     input logic [31:0] cd, input logic fs, input logic [7:0] ra);
    logic [1:0] op;
    logic       perr, cerr, cmt;
    int         shadow;
    phase_wr_en = pe; phase_wr_data = pd;
    calib_wr_en = ce; calib_wr_data = cd;
    frame_start = fs; rd_addr = ra;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_bank[0][i] = 8'h00; m_bank[1][i] = 8'h00; m_calib[i] = 8'h00;
      end
      m_left = N; m_act = 0; m_pend = 0; m_swap = 0; m_err = 0; m_rd = 0; m_fc = 0;
    end else if (m_left > 0) begin
      m_left--; m_rd = 0; m_swap = 0; m_err = pe | ce;
    end else begin
      m_rd   = 8'((int'(m_bank[m_act ? 1 : 0][ra]) + int'(m_calib[ra])) % 256);
      m_swap = fs && m_pend;
      op     = pd[17:16];
      perr   = pe && (int'(pd[7:0]) >= N || op == 2'b00 || op == 2'b11);
      cmt    = pe && !perr && op == 2'b10;
      shadow = m_act ? 0 : 1;
      if (pe && !perr && op == 2'b01) m_bank[shadow][pd[7:0]] = pd[15:8];
      cerr   = ce && int'(cd[7:0]) >= N;
      if (ce && !cerr) m_calib[cd[7:0]] = cd[15:8];
      m_err  = perr || cerr;
      if (m_swap) begin
        m_pend = 0; m_act = !m_act; m_fc = m_fc + 16'd1;
      end else if (cmt) begin
        m_pend = 1;
      end
    end
    #1;
    chk("rd_phase", 32'(rd_phase), 32'(m_rd));
    chk("active_bank", 32'(active_bank), 32'(m_act));
    chk("commit_pending", 32'(commit_pending), 32'(m_pend));
    chk("swap_pulse", 32'(swap_pulse), 32'(m_swap));
    chk("cmd_error", 32'(cmd_error), 32'(m_err));
    chk("clearing", 32'(clearing), 32'(m_left > 0));
    chk("frame_count", 32'(frame_count), 32'(m_fc));
  endtask

  task automatic idle(input logic [7:0] ra);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, ra);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) idle(8'h00);
    rst = 1'b0;
  endtask

  initial begin
    logic        pe, ce, fs;
    logic [1:0]  op;
    logic [7:0]  a, ra, ca;
    int          r;

    // Reset sweep, with rejected writes injected mid-sweep
    do_reset(2);
    for (int i = 0; i < N; i++) begin
      if (i == 50) cyc(1'b1, pw(2'b01, 8'h55, 8'd3), 1'b1, cw(8'd3, 8'h11), 1'b0, 8'd3);
      else if (i == 60) cyc(1'b1, pw(2'b10, 8'h00, 8'd0), 1'b0, 32'h0, 1'b1, 8'd0);
      else idle(8'(i));
    end
    chk("clear_done", 32'(clearing), 32'h0);
    for (int i = 0; i < N; i++) idle(8'(i));
    idle(8'd3);
    chk("clr_write_dropped", 32'(rd_phase), 32'h0);

    // Atomic swap
    cyc(1'b1, pw(2'b01, 8'h40, 8'd5), 1'b0, 32'h0, 1'b0, 8'd5);
    idle(8'd5);
    chk("pre_swap_rd5", 32'(rd_phase), 32'h00);
    cyc(1'b1, pw(2'b10, 8'h00, 8'd0), 1'b0, 32'h0, 1'b0, 8'd5);
    idle(8'd5);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 8'd5);
    chk("swap_pulse_1", 32'(swap_pulse), 32'h1);
    chk("active_after_swap", 32'(active_bank), 32'h1);
    chk("fc_after_swap", 32'(frame_count), 32'h1);
    idle(8'd5);
    chk("post_swap_rd5", 32'(rd_phase), 32'h40);

    // Calibration wrap
    cyc(1'b0, 32'h0, 1'b1, cw(8'd5, 8'hF0), 1'b0, 8'd5);
    idle(8'd5);
    chk("calib_wrap_rd5", 32'(rd_phase), 32'h30);

    // Same-cycle phase write and swap
    cyc(1'b1, pw(2'b10, 8'h00, 8'd0), 1'b0, 32'h0, 1'b0, 8'd9);
    idle(8'd9);
    cyc(1'b1, pw(2'b01, 8'h77, 8'd9), 1'b0, 32'h0, 1'b1, 8'd9);
    idle(8'd9);
    chk("same_cycle_rd9", 32'(rd_phase), 32'h77);

    // Bad opcode and double commit
    cyc(1'b1, pw(2'b11, 8'h12, 8'd9), 1'b0, 32'h0, 1'b0, 8'd9);
    chk("err_op11", 32'(cmd_error), 32'h1);
    idle(8'd9);
    chk("err_clears", 32'(cmd_error), 32'h0);
    chk("op11_no_change", 32'(rd_phase), 32'h77);
    cyc(1'b1, pw(2'b10, 8'h00, 8'd0), 1'b0, 32'h0, 1'b0, 8'd9);
    cyc(1'b1, pw(2'b10, 8'h00, 8'd0), 1'b0, 32'h0, 1'b0, 8'd9);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 8'd9);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 8'd9);
    chk("double_commit_fc", 32'(frame_count), 32'h3);

    // Randomized traffic concentrated on a few channels
    for (int n = 0; n < 3000; n++) begin
      pe = ($urandom_range(0, 2) == 0);
      r  = $urandom_range(0, 9);
      op = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 4) ? 2'b10 : 2'b01;
      a  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      ca = 8'($urandom_range(0, 15));
      ce = ($urandom_range(0, 7) == 0);
      fs = ($urandom_range(0, 9) == 0);
      ra = 8'($urandom_range(0, 15));
      cyc(pe, pw(op, 8'($urandom), a), ce, cw(ca, 8'($urandom)), fs, ra);
    end

    // Mid-sweep reset with a commit pending and swaps counted
    cyc(1'b1, pw(2'b10, 8'h00, 8'd0), 1'b0, 32'h0, 1'b0, 8'd0);
    idle(8'd0);
    do_reset(2);
    for (int i = 0; i < 100; i++) idle(8'(i));
    do_reset(2);
    chk("midreset_pending", 32'(commit_pending), 32'h0);
    chk("midreset_fc", 32'(frame_count), 32'h0);
    for (int i = 0; i < N + 4; i++) idle(8'(i));
    chk("midreset_done", 32'(clearing), 32'h0);
    for (int i = 0; i < 16; i++) idle(8'(i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/phase_bank_ctrl.md
# phase_bank_ctrl

Double-buffered phase store and commit scheduler between the host command receiver and the transducer PWM generators. It accepts phase and calibration writes from the receiver and stages phase writes in a shadow bank. On a host commit it swaps shadow and active banks at the next PWM frame boundary, so a burst of phase updates takes effect atomically. The PWM side reads the calibrated phase, (active + calibration) mod 2^PHASE_W, through a registered read port.

## Interface
- NUM_CHANNELS, 256: number of transducer channels; power of two, ≤ 256.
- PHASE_W, 8: phase and calibration word width.
- ADDR_W, 8: channel address width; NUM_CHANNELS ≤ 2^ADDR_W.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- phase_wr_en  in  1  one-cycle strobe; phase_wr_data is valid.
- phase_wr_data  in  32  command word: [7:0] addr, [15:8] phase, [17:16] opcode, [31:18] ignored.
- calib_wr_en  in  1  one-cycle strobe; calib_wr_data [7:0] is addr and [15:8] is the offset.
- calib_wr_data  in  32  calibration write word.
- frame_start  in  1  one-cycle pulse at each PWM period boundary.
- rd_addr  in  ADDR_W  PWM read address.
- rd_phase  out  PHASE_W  calibrated phase for the rd_addr presented one cycle earlier.
- active_bank  out  1  index of the bank currently driving rd_phase.
- commit_pending  out  1  a commit was accepted and the swap has not yet happened.
- swap_pulse  out  1  one-cycle pulse in the cycle after a swap.
- clearing  out  1  high while the post-reset clear sweep runs.
- cmd_error  out  1  one-cycle pulse when a write is rejected.
- frame_count  out  16  number of swaps performed; wraps at 2^16.

## Operation
- Storage:
  - Two phase banks, bank0 and bank1, each NUM_CHANNELS x PHASE_W.
  - One calibration array, NUM_CHANNELS x PHASE_W.
  - The shadow bank is always !active_bank.
- State machine, CLEAR -> RUN:
  - rst forces CLEAR with clr_addr = 0.
  - CLEAR writes 0 to bank0[clr_addr], bank1[clr_addr] and calib[clr_addr], then increments clr_addr. This takes one cycle per address, NUM_CHANNELS cycles total.
  - CLEAR moves to RUN after the write to address NUM_CHANNELS-1.
  - rst asserted in any state, including mid-sweep, restarts CLEAR from address 0.
- Phase opcodes in RUN (phase_wr_data[17:16]):
  - 2'b01: write phase into shadow[addr].
  - 2'b10: commit; sets commit_pending. A commit while one is already pending has no further effect and is not an error.
  - 2'b00 and 2'b11: rejected, cmd_error pulses.
- Calibration writes in RUN store the offset into calib[addr] immediately. They affect rd_phase from the next read.
- Rejection rules; cmd_error pulses and no storage changes when:
  - any write arrives during CLEAR;
  - addr ≥ NUM_CHANNELS.
- Simultaneous phase and calibration strobes are both serviced. cmd_error pulses once if either strobe is rejected.
- Swap: on a frame_start cycle in RUN with commit_pending = 1, the registered results are:
  - active_bank toggles;
  - commit_pending clears;
  - frame_count increments;
  - swap_pulse = 1 for one cycle.
- frame_start with commit_pending = 0 does nothing.
- A frame_start during CLEAR is ignored, and commit_pending cannot be set during CLEAR.
- A phase write in the same cycle as a swap targets the pre-swap shadow bank, which becomes active. The write is therefore visible in the new frame.
- A commit in the same cycle as frame_start sets commit_pending. The swap waits for the next frame_start.
- The new shadow bank is not copied from the active bank after a swap. It holds the frame from two commits ago, and the host rewrites every channel it wants changed.

## Timing
- Reset values:
  - rd_phase = 0, active_bank = 0, commit_pending = 0;
  - swap_pulse = 0, cmd_error = 0, frame_count = 0;
  - clearing = 1.
- clearing deasserts on the first cycle in RUN, which is NUM_CHANNELS cycles after rst deasserts.
- rd_phase latency is 1 cycle: rd_phase(t+1) = (active[rd_addr(t)] + calib[rd_addr(t)]) mod 2^PHASE_W.
- rd_phase reads 0 during CLEAR.
- Bank reads use the active_bank value registered at cycle t. rd_phase switches to the new bank starting with the read issued in the cycle after the swap edge.
- Write latency: a write at cycle t is readable by an rd_addr presented at t+1. For a phase write, the target bank must also be active at that point.
- commit_pending rises the cycle after the commit strobe.
- cmd_error is registered and pulses the cycle after the offending strobe.
- frame_count rolls over from 0xFFFF to 0x0000 with no flag.

## Test plan
- Reset sweep: rst for 2 cycles, then release -> clearing is high for exactly 256 cycles and cmd_error = 0. After that, rd_phase = 0 for every address.
- Atomic swap: write addr 5 = 0x40 (opcode 01), read addr 5 -> rd_phase = 0x00. Commit, then frame_start -> swap_pulse = 1, active_bank = 1, frame_count = 1, and a read of addr 5 returns 0x40.
- Calibration wrap: calib[5] = 0xF0 with active phase 0x40 -> rd_phase = 0x30, one cycle after rd_addr = 5.
- Same-cycle write and swap: commit pending, then a phase write to addr 9 = 0x77 in the frame_start cycle -> after the swap, a read of addr 9 returns 0x77.
- Errors: opcode 2'b11 -> cmd_error = 1 for one cycle, no state change. A write during CLEAR -> cmd_error = 1 and the value is not stored. A double commit before frame_start -> exactly one swap.
- Mid-sweep reset: assert rst at clr_addr = 100 -> clearing stays high for a full 256 cycles after release. Pending commits and frame_count return to 0.
